i2c_sequencer: RTL

I2C_SEQUENCER -- requirements
Module: i2c_sequencer

---
 rtl/i2c_seq_pkg.sv | 33 +++
 rtl/fifo.sv | 57 +++++
 rtl/i2c_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C register-access sequencer.
// Holds the sequencer state encoding, R/W bit values, byte widths and
// the default progress timeout.
package i2c_seq_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned SLAVE_ADDR_W = 7;
  localparam int unsigned TMO_W        = 16;

  localparam logic READ_BIT  = 1'b1;
  localparam logic WRITE_BIT = 1'b0;

  localparam logic [TMO_W-1:0] TIMEOUT_DEFAULT = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WAIT_READY = 4'd1,
    ADDR_W     = 4'd2,
    REG        = 4'd3,
    WDATA      = 4'd4,
    ADDR_R     = 4'd5,
    RDATA      = 4'd6,
    FINISH     = 4'd7,
    ABORT      = 4'd8
  } seqState_t;

  // States in which the byte master is being driven (nack/timeout apply).
  function automatic logic isActive(input seqState_t s);
    return (s == WAIT_READY) || (s == ADDR_W) || (s == REG) ||
           (s == WDATA) || (s == ADDR_R) || (s == RDATA);
  endfunction

endpackage

// File: rtl/fifo.sv
// Byte FIFO, 2**FIFO_SIZE_EXP entries, first-word fall-through read.
// Ports: clk, reset (sync, active high), flush (empties the FIFO),
//        put/dataIn/full (fill side), get/dataOut/empty (drain side).
// A put while full or a get while empty is ignored.
module fifo
  import i2c_seq_pkg::*;
#(
  parameter int unsigned FIFO_SIZE_EXP = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              put,
  input  logic [BYTE_W-1:0] dataIn,
  output logic              full,
  input  logic              get,
  output logic [BYTE_W-1:0] dataOut,
  output logic              empty
);

  localparam int unsigned DEPTH = 1 << FIFO_SIZE_EXP;
  localparam int unsigned PTR_W = FIFO_SIZE_EXP;
  localparam int unsigned CNT_W = FIFO_SIZE_EXP + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic              doPut;
  logic              doGet;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPut   = put && !full;
  assign doGet   = get && !empty;
  assign dataOut = mem[rdPtr];

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (doPut) mem[wrPtr] <= dataIn;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPut) wrPtr <= wrPtr + PTR_W'(1);
      if (doGet) rdPtr <= rdPtr + PTR_W'(1);
      if (doPut && !doGet)      count <= count + CNT_W'(1);
      else if (!doPut && doGet) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_sequencer.sv
// Register-access sequencer on top of a byte-level I2C master.
// Runs: START addr+W, reg byte, optional write bytes from the tx FIFO,
// optional RESTART addr+R and read bytes into the rx FIFO, then done.
// Ports:
//   cmd_valid/cmd_ready, cmd_addr, cmd_reg, cmd_wlen, cmd_rlen : command
//   tx_put/tx_data/tx_full   : write-data FIFO fill
//   rx_get/rx_data/rx_empty  : read-data FIFO drain
//   isReady, start, send, receive, datasend, sended, received,
//   datareceive, nack        : byte-master handshake
//   busy, done, error        : status (done/error one-cycle pulses)
module i2c_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned      TX_DEPTH_EXP = 3,
  parameter int unsigned      RX_DEPTH_EXP = 3,
  parameter int unsigned      LEN_W        = 8,
  parameter logic [TMO_W-1:0] TIMEOUT      = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [SLAVE_ADDR_W-1:0] cmd_addr,
  input  logic [BYTE_W-1:0]       cmd_reg,
  input  logic [LEN_W-1:0]        cmd_wlen,
  input  logic [LEN_W-1:0]        cmd_rlen,
  input  logic                    tx_put,
  input  logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_full,
  input  logic                    rx_get,
  output logic [BYTE_W-1:0]       rx_data,
  output logic                    rx_empty,
  input  logic                    isReady,
  output logic                    start,
  output logic                    send,
  output logic                    receive,
  output logic [BYTE_W-1:0]       datasend,
  input  logic                    sended,
  input  logic                    received,
  input  logic [BYTE_W-1:0]       datareceive,
  input  logic                    nack,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  seqState_t                state;
  seqState_t                nextState;
  logic [SLAVE_ADDR_W-1:0]  addrQ;
  logic [BYTE_W-1:0]        regQ;
  logic [LEN_W-1:0]         wlenQ;
  logic [LEN_W-1:0]         rlenQ;
  logic [TMO_W-1:0]         tmoCnt;

  logic                     accept;
  logic                     txPop;
  logic                     rxPush;
  logic                     txFlush;
  logic                     tmoHit;
  logic                     ctrlStart;
  logic                     ctrlSend;
  logic                     ctrlReceive;
  logic [BYTE_W-1:0]        ctrlData;

  logic                     txEmpty;
  logic [BYTE_W-1:0]        txHead;
  logic                     rxFull;

  fifo #(.FIFO_SIZE_EXP(TX_DEPTH_EXP)) txFifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (txFlush),
    .put    (tx_put),
    .dataIn (tx_data),
    .full   (tx_full),
    .get    (txPop),
    .dataOut(txHead),
    .empty  (txEmpty)
  );

  fifo #(.FIFO_SIZE_EXP(RX_DEPTH_EXP)) rxFifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (1'b0),
    .put    (rxPush),
    .dataIn (datareceive),
    .full   (rxFull),
    .get    (rx_get),
    .dataOut(rx_data),
    .empty  (rx_empty)
  );

  // State register, command latches, byte counters and progress timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addrQ  <= '0;
      regQ   <= '0;
      wlenQ  <= '0;
      rlenQ  <= '0;
      tmoCnt <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        addrQ <= cmd_addr;
        regQ  <= cmd_reg;
        wlenQ <= cmd_wlen;
        rlenQ <= cmd_rlen;
      end
      if (txPop)  wlenQ <= wlenQ - LEN_W'(1);
      if (rxPush) rlenQ <= rlenQ - LEN_W'(1);
      if (state == IDLE || nextState != state || sended || received)
        tmoCnt <= '0;
      else
        tmoCnt <= tmoCnt + TMO_W'(1);
    end
  end

  // Next state, FIFO strobes and control decode of the current state.
  always_comb begin
    nextState   = state;
    accept      = 1'b0;
    txPop       = 1'b0;
    rxPush      = 1'b0;
    txFlush     = 1'b0;
    ctrlStart   = 1'b0;
    ctrlSend    = 1'b0;
    ctrlReceive = 1'b0;
    ctrlData    = '0;
    tmoHit      = (tmoCnt == TIMEOUT - TMO_W'(1));

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          nextState = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (isReady) nextState = ADDR_W;
      end
      ADDR_W: begin
        ctrlData  = {addrQ, WRITE_BIT};
        ctrlStart = 1'b1;
        ctrlSend  = 1'b1;
        if (sended) nextState = REG;
      end
      REG: begin
        ctrlData = regQ;
        ctrlSend = 1'b1;
        if (sended) begin
          if (wlenQ != '0)      nextState = WDATA;
          else if (rlenQ != '0) nextState = ADDR_R;
          else                  nextState = FINISH;
        end
      end
      WDATA: begin
        ctrlData = txEmpty ? '0 : txHead;
        ctrlSend = !txEmpty;
        if (sended) begin
          txPop = 1'b1;
          if (wlenQ == LEN_W'(1))
            nextState = (rlenQ != '0) ? ADDR_R : FINISH;
        end
      end
      ADDR_R: begin
        ctrlData  = {addrQ, READ_BIT};
        ctrlStart = 1'b1;
        ctrlSend  = 1'b1;
        if (sended) nextState = RDATA;
      end
      RDATA: begin
        ctrlReceive = !rxFull;
        if (received) begin
          // A byte delivered into a full rx FIFO is lost; report it.
          if (rxFull) begin
            nextState = ABORT;
          end else begin
            rxPush = 1'b1;
            if (rlenQ == LEN_W'(1)) nextState = FINISH;
          end
        end
      end
      FINISH: nextState = IDLE;
      ABORT: begin
        txFlush   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    // Slave NACK or a stalled master overrides normal progress.
    if (isActive(state) && (nack || tmoHit)) begin
      nextState = ABORT;
      txPop     = 1'b0;
      rxPush    = 1'b0;
    end
  end

  // Registered outputs: status tracks the state being entered,
  // master controls follow the current state one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      start     <= 1'b0;
      send      <= 1'b0;
      receive   <= 1'b0;
      datasend  <= '0;
    end else begin
      cmd_ready <= (nextState == IDLE);
      busy      <= (nextState != IDLE);
      done      <= (nextState == FINISH);
      error     <= (nextState == ABORT);
      start     <= ctrlStart;
      send      <= ctrlSend;
      receive   <= ctrlReceive;
      datasend  <= ctrlData;
    end
  end

endmodule
